sw_target_feeder: RTL and testbench

//  Transmit side of the PE-array target interface. Buffers one packed target sequence and

---
 rtl/sw_target_feeder.sv | 145 ++++++++++++++
 tb/tb_sw_target_feeder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_target_feeder.sv
// Buffers one packed target sequence and streams it into PE[0] as a contiguous en/data burst,
// followed by the idle gap the PE array needs between sequences.
module sw_target_feeder #(
  parameter int SCORE_WIDTH = 12,
  parameter int ZERO        = 2**(SCORE_WIDTH-1),
  parameter int WORD_W      = 32,
  parameter int MAX_LEN     = 1024,
  parameter int LEN_W       = $clog2(MAX_LEN+1),
  parameter int GAP_CYCLES  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  input  logic [WORD_W-1:0]      word_in,
  input  logic                   word_valid,
  output logic                   word_ready,
  output logic                   en_out,
  output logic [1:0]             data_out,
  output logic [SCORE_WIDTH-1:0] M_out,
  output logic [SCORE_WIDTH-1:0] I_out,
  output logic [SCORE_WIDTH-1:0] High_out,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int BPW   = WORD_W / 2;
  localparam int BW    = $clog2(BPW);
  localparam int DEPTH = MAX_LEN / BPW;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] GAP    = 2'd3;

  logic [1:0]        state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  words_needed;
  logic [LEN_W-1:0]  wr_idx;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  cnt_inc;
  logic              primed;
  logic [GW-1:0]     gap_cnt;
  logic [WORD_W-1:0] buffer [DEPTH];
  logic [WORD_W-1:0] rd_word;
  logic [AW-1:0]     rd_addr;
  logic [BW-1:0]     base_sel;
  logic [LEN_W:0]    len_round;
  logic              len_bad;

  assign M_out    = SCORE_WIDTH'(ZERO);
  assign I_out    = SCORE_WIDTH'(ZERO);
  assign High_out = SCORE_WIDTH'(ZERO);

  assign word_ready = (state == LOAD);
  assign len_bad    = (len == '0) || (len > LEN_W'(MAX_LEN));
  assign len_round  = {1'b0, len} + (LEN_W+1)'(BPW - 1);
  assign cnt_inc    = cnt + 1'b1;
  assign base_sel   = BW'(cnt);

  // The read word is always one base ahead of data_out: it holds the word of the base
  // that the next edge emits, so word boundaries need no bubble.
  assign rd_addr = primed ? AW'(cnt_inc >> BW) : '0;

  always_ff @(posedge clk) begin
    if (state == LOAD && word_valid) begin
      buffer[AW'(wr_idx)] <= word_in;
    end
    rd_word <= buffer[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      len_q        <= '0;
      words_needed <= '0;
      wr_idx       <= '0;
      cnt          <= '0;
      primed       <= 1'b0;
      gap_cnt      <= '0;
      en_out       <= 1'b0;
      data_out     <= 2'b00;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse belongs to the finished sequence.
          if (start && !done) begin
            if (len_bad) begin
              err <= 1'b1;
            end else begin
              len_q        <= len;
              words_needed <= LEN_W'(len_round >> BW);
              wr_idx       <= '0;
              cnt          <= '0;
              primed       <= 1'b0;
              busy         <= 1'b1;
              state        <= LOAD;
            end
          end
        end
        LOAD: begin
          if (word_valid) begin
            wr_idx <= wr_idx + 1'b1;
            if (wr_idx == words_needed - 1'b1) begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (!primed) begin
            primed <= 1'b1;
          end else if (cnt == len_q) begin
            en_out   <= 1'b0;
            data_out <= 2'b00;
            gap_cnt  <= '0;
            state    <= GAP;
          end else begin
            en_out   <= 1'b1;
            data_out <= rd_word[{base_sel, 1'b0} +: 2];
            cnt      <= cnt_inc;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_target_feeder.sv
// Self-checking bench for sw_target_feeder: randomized words and lengths against a
// base-extraction reference model.
module tb_sw_target_feeder;
  localparam int LEN_W = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [31:0]       word_in;
  logic              word_valid;
  logic              word_ready;
  logic              en_out;
  logic [1:0]        data_out;
  logic [11:0]       M_out;
  logic [11:0]       I_out;
  logic [11:0]       High_out;
  logic              busy;
  logic              done;
  logic              err;

  sw_target_feeder dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .word_in(word_in),
    .word_valid(word_valid), .word_ready(word_ready), .en_out(en_out),
    .data_out(data_out), .M_out(M_out), .I_out(I_out), .High_out(High_out),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int score_bad = 0;
  int idle_bad = 0;
  int err_total = 0;
  int done_total = 0;
  int completed = 0;
  bit mon_on = 1'b0;

  logic [31:0] words[$];
  logic [1:0]  got[$];
  int lat, burst_len, gap_lo, busy_bad;
  bit timeout, wr_after, done_seen, busy_at_done;

  always @(negedge clk) begin
    if (mon_on) begin
      if (M_out !== 12'h800 || I_out !== 12'h800 || High_out !== 12'h800) score_bad++;
      if (en_out !== 1'b1 && data_out !== 2'b00) idle_bad++;
      if (err === 1'b1) err_total++;
      if (done === 1'b1) done_total++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: base i is bit pair i%16 of packed word i/16, LSB first.
  function automatic logic [1:0] exp_base(int i);
    logic [31:0] w;
    w = words[i/16];
    return w[2*(i%16) +: 2];
  endfunction

  function automatic int count_mism(int n);
    int m = 0;
    for (int i = 0; i < n; i++)
      if (i >= got.size() || got[i] !== exp_base(i)) m++;
    return m;
  endfunction

  task automatic fill_words(input int n);
    words.delete();
    for (int k = 0; k < (n + 15) / 16; k++) words.push_back($urandom);
  endtask

  // vmode: 0 always valid, 1 random valid, 2 valid pattern 1-0-0-1-...
  task automatic run_seq(input int n, input int vmode, input bit mid_start, input bit abort);
    int k, c, guard;
    got.delete();
    lat = 0; burst_len = 0; gap_lo = 0; busy_bad = 0;
    timeout = 0; wr_after = 1'b1; done_seen = 0; busy_at_done = 1'b1;
    @(posedge clk); #1; start = 1'b1; len = LEN_W'(n);
    @(posedge clk); #1; start = 1'b0;
    k = 0; c = 0; guard = 0;
    while (k < words.size() && guard < 5000) begin
      word_in = words[k];
      case (vmode)
        0: word_valid = 1'b1;
        1: word_valid = 1'($urandom_range(0, 1));
        default: word_valid = (c % 3 == 0);
      endcase
      @(negedge clk);
      if (word_valid && word_ready) k++;
      @(posedge clk); #1;
      c++; guard++;
    end
    word_valid = 1'b0;
    if (guard >= 5000) timeout = 1;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) wr_after = word_ready;
    end while (en_out !== 1'b1 && lat < 20);
    while (en_out === 1'b1 && burst_len < n + 10) begin
      got.push_back(data_out);
      burst_len++;
      if (busy !== 1'b1) busy_bad++;
      if (abort && burst_len == 4) begin
        rst = 1'b1;
        return;
      end
      if (mid_start) start = (burst_len == 2);
      @(negedge clk);
    end
    start = 1'b0;
    while (done !== 1'b1 && gap_lo < 20) begin
      gap_lo++;
      @(negedge clk);
    end
    done_seen = done;
    busy_at_done = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; len = '0; word_in = '0; word_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (en_out !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", en_out); end
    checks++; if (data_out !== 2'b00) begin errors++; $display("FAIL reset_data: got %b expected 00", data_out); end
    checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", word_ready); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got busy/done/err=%b expected 000", {busy, done, err}); end
    checks++; if (M_out !== 12'h800 || High_out !== 12'h800) begin errors++; $display("FAIL reset_scores: got M=%h High=%h expected 800", M_out, High_out); end
    rst = 1'b0;
    mon_on = 1'b1;
  endtask

  task automatic test_single();
    logic [1:0] e [5];
    e = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    words.delete(); words.push_back(32'h0000_00E4);
    run_seq(5, 0, 0, 0);
    completed++;
    checks++; if (timeout) begin errors++; $display("FAIL single_load: got timeout expected all words accepted"); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL single_latency: got %0d expected 3", lat); end
    checks++; if (wr_after !== 1'b0) begin errors++; $display("FAIL single_ready_drop: got %b expected 0", wr_after); end
    checks++; if (burst_len !== 5) begin errors++; $display("FAIL single_burst_len: got %0d expected 5", burst_len); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== e[i]) begin
        errors++; $display("FAIL single_base%0d: got %b expected %b", i, (i < got.size()) ? got[i] : 2'bxx, e[i]);
      end
    end
    checks++; if (gap_lo !== 2) begin errors++; $display("FAIL single_gap: got %0d expected 2", gap_lo); end
    checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL single_done: got %b expected 1", done_seen); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL single_busy_at_done: got %b expected 0", busy_at_done); end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL single_busy_burst: got %0d low cycles expected 0", busy_bad); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b expected 0", done); end
  endtask

  task automatic test_gappy_load();
    logic [31:0] w1;
    fill_words(17);
    w1 = words[1];
    run_seq(17, 2, 0, 0);
    completed++;
    checks++; if (burst_len !== 17) begin errors++; $display("FAIL gappy_burst_len: got %0d expected 17", burst_len); end
    checks++; if (count_mism(17) !== 0) begin errors++; $display("FAIL gappy_bases: got %0d mismatches expected 0", count_mism(17)); end
    checks++; if (got.size() < 17 || got[16] !== w1[1:0]) begin errors++; $display("FAIL gappy_base16: got %b expected %b", (got.size() >= 17) ? got[16] : 2'bxx, w1[1:0]); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL gappy_latency: got %0d expected 3", lat); end
    checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL gappy_done: got %b expected 1", done_seen); end
    @(negedge clk);
  endtask

  task automatic test_illegal_len();
    int bad [2];
    bad = '{0, 1025};
    for (int t = 0; t < 2; t++) begin
      @(posedge clk); #1; start = 1'b1; len = LEN_W'(bad[t]);
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_pulse_len%0d: got %b expected 1", bad[t], err); end
      checks++; if ({busy, word_ready, en_out} !== 3'b000) begin errors++; $display("FAIL err_idle_len%0d: got busy/ready/en=%b expected 000", bad[t], {busy, word_ready, en_out}); end
      @(negedge clk);
      checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL err_after_len%0d: got err/busy=%b%b expected 00", bad[t], err, busy); end
    end
  endtask

  task automatic test_back_to_back();
    fill_words(20);
    run_seq(20, 1, 1, 0);
    completed++;
    checks++; if (burst_len !== 20) begin errors++; $display("FAIL b2b_first_len: got %0d expected 20", burst_len); end
    checks++; if (count_mism(20) !== 0) begin errors++; $display("FAIL b2b_first_bases: got %0d mismatches expected 0", count_mism(20)); end
    checks++; if (gap_lo < 2) begin errors++; $display("FAIL b2b_gap: got %0d expected >=2", gap_lo); end
    checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b expected 1", done_seen); end
    start = 1'b1; len = LEN_W'(5);
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0 || word_ready !== 1'b0) begin errors++; $display("FAIL b2b_done_cycle_start: got busy/ready=%b%b expected 00", busy, word_ready); end
    fill_words(33);
    run_seq(33, 0, 0, 0);
    completed++;
    checks++; if (burst_len !== 33) begin errors++; $display("FAIL b2b_second_len: got %0d expected 33", burst_len); end
    checks++; if (count_mism(33) !== 0) begin errors++; $display("FAIL b2b_second_bases: got %0d mismatches expected 0", count_mism(33)); end
    checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b expected 1", done_seen); end
    @(negedge clk);
  endtask

  task automatic test_reset_in_stream();
    int d0;
    fill_words(20);
    run_seq(20, 0, 0, 1);
    checks++; if (got.size() !== 4 || count_mism(4) !== 0) begin errors++; $display("FAIL rst_pre_bases: got %0d bases %0d mismatches expected 4 0", got.size(), count_mism(4)); end
    @(negedge clk);
    checks++; if (en_out !== 1'b0 || data_out !== 2'b00) begin errors++; $display("FAIL rst_stream_outputs: got en=%b data=%b expected 0 00", en_out, data_out); end
    checks++; if ({busy, done, word_ready} !== 3'b000) begin errors++; $display("FAIL rst_stream_flags: got busy/done/ready=%b expected 000", {busy, done, word_ready}); end
    rst = 1'b0;
    d0 = done_total;
    repeat (10) @(negedge clk);
    checks++; if (done_total !== d0) begin errors++; $display("FAIL rst_no_done: got %0d pulses expected 0", done_total - d0); end
    words.delete(); words.push_back(32'h0000_00E4);
    run_seq(5, 0, 0, 0);
    completed++;
    checks++; if (burst_len !== 5 || count_mism(5) !== 0) begin errors++; $display("FAIL rst_rerun: got len %0d mismatches %0d expected 5 0", burst_len, count_mism(5)); end
    checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL rst_rerun_done: got %b expected 1", done_seen); end
    @(negedge clk);
  endtask

  task automatic test_full_length();
    fill_words(1024);
    run_seq(1024, 1, 0, 0);
    completed++;
    checks++; if (timeout) begin errors++; $display("FAIL full_load: got timeout expected 64 words accepted"); end
    checks++; if (burst_len !== 1024) begin errors++; $display("FAIL full_burst_len: got %0d expected 1024", burst_len); end
    checks++; if (count_mism(1024) !== 0) begin errors++; $display("FAIL full_bases: got %0d mismatches expected 0", count_mism(1024)); end
    checks++; if (done_seen !== 1'b1 || gap_lo !== 2) begin errors++; $display("FAIL full_done: got done=%b gap=%0d expected 1 2", done_seen, gap_lo); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_done_once: got %b expected 0", done); end
  endtask

  task automatic test_random_lengths();
    int n;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 80);
      fill_words(n);
      run_seq(n, 1, 0, 0);
      completed++;
      checks++; if (burst_len !== n) begin errors++; $display("FAIL rand%0d_len: got %0d expected %0d", r, burst_len, n); end
      checks++; if (count_mism(n) !== 0) begin errors++; $display("FAIL rand%0d_bases: got %0d mismatches expected 0", r, count_mism(n)); end
      checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL rand%0d_done: got %b expected 1", r, done_seen); end
      @(negedge clk);
    end
  endtask

  task automatic test_static_outputs();
    @(negedge clk);
    checks++; if (score_bad !== 0) begin errors++; $display("FAIL scores_constant: got %0d bad cycles expected 0", score_bad); end
    checks++; if (idle_bad !== 0) begin errors++; $display("FAIL idle_data_zero: got %0d bad cycles expected 0", idle_bad); end
    checks++; if (err_total !== 2) begin errors++; $display("FAIL err_count: got %0d expected 2", err_total); end
    checks++; if (done_total !== completed) begin errors++; $display("FAIL done_count: got %0d expected %0d", done_total, completed); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gappy_load();
    test_illegal_len();
    test_back_to_back();
    test_reset_in_stream();
    test_full_length();
    test_random_lengths();
    test_static_outputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
